sec_bus_desteering: RTL

SEC_BUS_DESTEERING -- requirements
Module: sec_bus_desteering

---
 rtl/sec_bus_desteering.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/sec_bus_desteering.sv
// Reassembles the 36-byte MSA secondary-data burst from 1/2/4 steered lanes into a 192-bit MSA word.
// Optional integrity checking of the redundant bytes is enabled by defining SEC_DESTEER_CHECK_EN.
`timescale 1ns/1ps

// state   | meaning
// IDLE    | waiting for the first valid cycle of a burst
// COLLECT | storing lane bytes until the burst length is reached
// DRAIN   | discarding bytes until sec_lane_vld drops
module sec_bus_desteering (
   input  logic         clk,
   input  logic         rst,
   input  logic [1:0]   rx_lane_count,
   input  logic [7:0]   sec_lane0,
   input  logic [7:0]   sec_lane1,
   input  logic [7:0]   sec_lane2,
   input  logic [7:0]   sec_lane3,
   input  logic         sec_lane_vld,
   output logic [191:0] msa,
   output logic         msa_vld,
   output logic         msa_err
);

   typedef enum logic [1:0] {IDLE, COLLECT, DRAIN} state_t;

   state_t       r_state;
   logic [5:0]   r_cnt;
   logic [1:0]   r_lc;
   logic [7:0]   r_b [0:35];

   logic [7:0]   w_b [0:35];
   logic [1:0]   w_lc;
   logic [5:0]   w_k;
   logic [5:0]   w_last_k;
   logic [191:0] w_msa;
   logic         w_bad;

   // The first byte of a burst is captured in IDLE, before the lane count is latched.
   assign w_lc = (r_state == IDLE) ? rx_lane_count : r_lc;
   assign w_k  = (r_state == IDLE) ? 6'd0 : r_cnt;

   always_comb begin
      w_b = r_b;
      case (w_lc)
         2'b00: w_b[w_k] = sec_lane0;
         2'b01: begin
            if (w_k < 6'd9) begin
               w_b[w_k]         = sec_lane0;
               w_b[w_k + 6'd9]  = sec_lane1;
            end else begin
               w_b[w_k + 6'd9]  = sec_lane0;
               w_b[w_k + 6'd18] = sec_lane1;
            end
         end
         2'b11: begin
            w_b[w_k]         = sec_lane0;
            w_b[w_k + 6'd9]  = sec_lane1;
            w_b[w_k + 6'd18] = sec_lane2;
            w_b[w_k + 6'd27] = sec_lane3;
         end
         default: ;
      endcase
   end

   always_comb begin
      case (r_lc)
         2'b00:   w_last_k = 6'd35;
         2'b01:   w_last_k = 6'd17;
         default: w_last_k = 6'd8;
      endcase
   end

   assign w_msa = {w_b[0],  w_b[1],  w_b[2],  w_b[30], w_b[31], w_b[32],
                   w_b[3],  w_b[4],  w_b[5],  w_b[6],  w_b[12], w_b[13],
                   w_b[14], w_b[15], w_b[7],  w_b[8],  w_b[16], w_b[17],
                   w_b[21], w_b[22], w_b[23], w_b[24], w_b[33], w_b[34]};

`ifdef SEC_DESTEER_CHECK_EN
   // Three redundant Mvid copies must match, and the reserved bytes must be zero.
   assign w_bad = ({w_b[9],  w_b[10], w_b[11]} != {w_b[0], w_b[1], w_b[2]}) ||
                  ({w_b[18], w_b[19], w_b[20]} != {w_b[0], w_b[1], w_b[2]}) ||
                  ({w_b[27], w_b[28], w_b[29]} != {w_b[0], w_b[1], w_b[2]}) ||
                  (w_b[25] != 8'h00) || (w_b[26] != 8'h00) || (w_b[35] != 8'h00);
`else
   assign w_bad = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_cnt   <= 6'd0;
         r_lc    <= 2'b00;
         msa     <= 192'd0;
         msa_vld <= 1'b0;
         msa_err <= 1'b0;
         for (int i = 0; i < 36; i++) r_b[i] <= 8'h00;
      end else begin
         msa_vld <= 1'b0;
         msa_err <= 1'b0;
         case (r_state)
            IDLE: begin
               if (sec_lane_vld) begin
                  if (rx_lane_count == 2'b10) begin
                     r_state <= DRAIN;
                  end else begin
                     r_lc    <= rx_lane_count;
                     r_b     <= w_b;
                     r_cnt   <= 6'd1;
                     r_state <= COLLECT;
                  end
               end
            end
            COLLECT: begin
               if (!sec_lane_vld) begin
                  msa_err <= 1'b1;
                  r_cnt   <= 6'd0;
                  r_state <= IDLE;
               end else if (r_cnt == w_last_k) begin
                  r_b     <= w_b;
                  r_cnt   <= 6'd0;
                  r_state <= DRAIN;
                  if (w_bad) begin
                     msa_err <= 1'b1;
                  end else begin
                     msa     <= w_msa;
                     msa_vld <= 1'b1;
                  end
               end else begin
                  r_b   <= w_b;
                  r_cnt <= r_cnt + 6'd1;
               end
            end
            DRAIN: begin
               if (!sec_lane_vld) r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule
